// File: rtl/riscv_csr_pkg.sv
// Shared definitions for the RV32 machine-mode CSR unit: access encodings,
// CSR addresses, mstatus layout and the constant misa value.
package riscv_csr_pkg;

    typedef enum logic [2:0] {
        CSR_NONE = 3'd0,
        CSR_RW   = 3'd1,
        CSR_RS   = 3'd2,
        CSR_RC   = 3'd3,
        CSR_RO   = 3'd4,
        CSR_WO   = 3'd5
    } csr_access_e;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MSTATUS_MPP_LO   = 11;
    localparam int MSTATUS_MPP_HI   = 12;

    localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

    // Machine-only core: MPP is hardwired to M-mode.
    function automatic logic [31:0] mstatus_pack(input logic mie, input logic mpie);
        logic [31:0] v;
        v = '0;
        v[MSTATUS_MIE_BIT]                = mie;
        v[MSTATUS_MPIE_BIT]               = mpie;
        v[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b11;
        return v;
    endfunction

endpackage

// File: rtl/riscv_csr_counter64.sv
// 64-bit free-running counter with per-word load; a load of either word
// takes the place of that cycle's increment.
module riscv_csr_counter64 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        inc_en_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] lo_o,
    output logic [31:0] hi_o
);

    logic [63:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (wr_lo_i || wr_hi_i) begin
            if (wr_lo_i) cnt_d[31:0]  = wdata_i;
            if (wr_hi_i) cnt_d[63:32] = wdata_i;
        end else if (inc_en_i) begin
            cnt_d = cnt_q + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign lo_o = cnt_q[31:0];
    assign hi_o = cnt_q[63:32];

endmodule

// File: rtl/riscv_i32_csr_unit.sv
// RV32 machine-mode CSR file: combinational read/decode, read-modify-write
// update, trap entry / mret handling and the cycle/instret counters.
module riscv_i32_csr_unit
    import riscv_csr_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        csr_access__access_cancelled,
    input  logic [2:0]  csr_access__access,
    input  logic [11:0] csr_access__address,
    input  logic [31:0] csr_access__write_data,
    input  logic        instr_retired,
    input  logic        trap__valid,
    input  logic [4:0]  trap__cause,
    input  logic        trap__interrupt,
    input  logic [31:0] trap__pc,
    input  logic [31:0] trap__value,
    input  logic        mret,
    output logic [31:0] csr_read_data,
    output logic        csr_illegal,
    output logic [31:0] mtvec,
    output logic [31:0] mepc,
    output logic        mstatus_mie
);

    logic        mie_q, mie_d, mpie_q, mpie_d;
    logic [31:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
    logic [31:0] cyc_lo, cyc_hi, ir_lo, ir_hi;

    logic        acc_active, acc_write, addr_known, wr_en;
    logic [31:0] rd_val, wr_val;
    logic [11:0] addr;

    assign addr = csr_access__address;

    always_comb begin
        acc_active = 1'b0;
        acc_write  = 1'b0;
        if (!csr_access__access_cancelled) begin
            acc_active = (csr_access__access == CSR_RW) || (csr_access__access == CSR_RS) ||
                         (csr_access__access == CSR_RC) || (csr_access__access == CSR_RO) ||
                         (csr_access__access == CSR_WO);
            acc_write  = acc_active && (csr_access__access != CSR_RO);
        end
    end

    always_comb begin
        addr_known = 1'b1;
        rd_val     = '0;
        case (addr)
            CSR_MSTATUS:               rd_val = mstatus_pack(mie_q, mpie_q);
            CSR_MISA:                  rd_val = MISA_VALUE;
            CSR_MTVEC:                 rd_val = mtvec_q;
            CSR_MSCRATCH:              rd_val = mscratch_q;
            CSR_MEPC:                  rd_val = mepc_q;
            CSR_MCAUSE:                rd_val = mcause_q;
            CSR_MTVAL:                 rd_val = mtval_q;
            CSR_MCYCLE,   CSR_CYCLE:   rd_val = cyc_lo;
            CSR_MCYCLEH,  CSR_CYCLEH:  rd_val = cyc_hi;
            CSR_MINSTRET, CSR_INSTRET: rd_val = ir_lo;
            CSR_MINSTRETH, CSR_INSTRETH: rd_val = ir_hi;
            default:                   addr_known = 1'b0;
        endcase
    end

    // 0xCxx is the user read-only window; misa has no meaningful blind write.
    assign csr_illegal = acc_active &&
                         (!addr_known ||
                          (acc_write && (addr[11:10] == 2'b11)) ||
                          ((csr_access__access == CSR_WO) && (addr == CSR_MISA)));

    assign csr_read_data = (acc_active && !csr_illegal && (csr_access__access != CSR_WO))
                           ? rd_val : 32'h0;

    assign wr_en = acc_write && !csr_illegal;

    always_comb begin
        case (csr_access__access)
            CSR_RS:  wr_val = rd_val | csr_access__write_data;
            CSR_RC:  wr_val = rd_val & ~csr_access__write_data;
            default: wr_val = csr_access__write_data;
        endcase
    end

    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        // Trap/mret own the trap-state CSRs for the cycle; software writes lose.
        if (wr_en) begin
            case (addr)
                CSR_MTVEC:    mtvec_d    = wr_val & 32'hFFFF_FFFC;
                CSR_MSCRATCH: mscratch_d = wr_val;
                default: ;
            endcase
            if (!trap__valid && !mret) begin
                case (addr)
                    CSR_MSTATUS: begin
                        mie_d  = wr_val[MSTATUS_MIE_BIT];
                        mpie_d = wr_val[MSTATUS_MPIE_BIT];
                    end
                    CSR_MEPC:   mepc_d   = wr_val & 32'hFFFF_FFFE;
                    CSR_MCAUSE: mcause_d = wr_val;
                    CSR_MTVAL:  mtval_d  = wr_val;
                    default: ;
                endcase
            end
        end
        if (trap__valid) begin
            mepc_d   = trap__pc & 32'hFFFF_FFFE;
            mcause_d = {trap__interrupt, 26'b0, trap__cause};
            mtval_d  = trap__value;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (mret) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
        end
    end

    riscv_csr_counter64 u_cycle (
        .clk      (clk),
        .reset_n  (reset_n),
        .inc_en_i (1'b1),
        .wr_lo_i  (wr_en && (addr == CSR_MCYCLE)),
        .wr_hi_i  (wr_en && (addr == CSR_MCYCLEH)),
        .wdata_i  (wr_val),
        .lo_o     (cyc_lo),
        .hi_o     (cyc_hi)
    );

    riscv_csr_counter64 u_instret (
        .clk      (clk),
        .reset_n  (reset_n),
        .inc_en_i (instr_retired),
        .wr_lo_i  (wr_en && (addr == CSR_MINSTRET)),
        .wr_hi_i  (wr_en && (addr == CSR_MINSTRETH)),
        .wdata_i  (wr_val),
        .lo_o     (ir_lo),
        .hi_o     (ir_hi)
    );

    assign mtvec       = mtvec_q;
    assign mepc        = mepc_q;
    assign mstatus_mie = mie_q;

endmodule
